// File: rtl/laser_cannon_if.sv
// laser_cannon_if: bundles the laser stage's control inputs, pixel
// coordinates and its outputs. The master side (ship/video/alien logic or a
// bench) drives the inputs; the slave side is the laser_cannon block itself.
`timescale 1ns/1ps
interface laser_cannon_if;
  logic       fire;
  logic       frame_tick;
  logic [9:0] gunPosition;
  logic       hit;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic       laser_active;
  logic [9:0] laser_x;
  logic [9:0] laser_y;
  logic       shot_done;
  logic [2:0] color;

  modport master (
    output fire, frame_tick, gunPosition, hit, hPos, vPos,
    input  laser_active, laser_x, laser_y, shot_done, color
  );

  modport slave (
    input  fire, frame_tick, gunPosition, hit, hPos, vPos,
    output laser_active, laser_x, laser_y, shot_done, color
  );
endinterface

// File: rtl/laser_cannon.sv
// laser_cannon: player laser stage. Launches one laser from the ship's nose,
// moves it up LASER_STEP pixels per frame, ends the shot at the top of the
// screen or on an alien hit, then waits COOLDOWN_FRAMES frames before the
// next launch is accepted. Also renders the laser as colour code 6 (LASER)
// with one cycle of latency; every other pixel gets 7 (NONE).
// Optional build macro LASER_AUTOFIRE_EN: when defined, IDLE launches on the
// fire level instead of its rising edge, so holding fire repeats shots.
`timescale 1ns/1ps
module laser_cannon #(
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int SHIP_TOP        = 440,
  parameter int LASER_WIDTH     = 3,
  parameter int LASER_HEIGHT    = 12,
  parameter int LASER_STEP      = 8,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic           clk,
  input  logic           reset,
  laser_cannon_if.slave  bus
);

  localparam logic [2:0] COLOR_LASER = 3'd6;
  localparam logic [2:0] COLOR_NONE  = 3'd7;

  localparam logic [9:0]  HALF_W   = 10'(LASER_WIDTH / 2);
  localparam logic [9:0]  X_MAX    = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0]  X_RESET  = 10'(SCREEN_WIDTH / 2);
  localparam logic [9:0]  LAUNCH_Y = 10'(SHIP_TOP - LASER_HEIGHT);
  localparam logic [9:0]  STEP     = 10'(LASER_STEP);
  localparam logic [10:0] Y_SPAN   = 11'(LASER_HEIGHT - 1);
  localparam logic [10:0] Y_MAX    = 11'(SCREEN_HEIGHT - 1);

  localparam int          CW       = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [9:0]    x_reg, x_next;
  logic [9:0]    y_reg, y_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          shot_done_reg, shot_done_next;
  logic          fire_q_reg;
  logic [2:0]    color_reg;

  logic          launch;
  logic          active;
  logic [9:0]    x_lo, x_hi;
  logic [10:0]   y_bot;
  logic          in_window;

  // Launch trigger: fire level in autofire builds, otherwise the rising edge
  // against the registered copy (which resets high so a held button is inert).
`ifdef LASER_AUTOFIRE_EN
  assign launch = bus.fire;
`else
  assign launch = bus.fire & ~fire_q_reg;
`endif

  assign active = (state_reg == FLYING);

  // Registered copy of the fire button for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q_reg <= 1'b1;
    end else begin
      fire_q_reg <= bus.fire;
    end
  end

  // State and laser position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      x_reg         <= X_RESET;
      y_reg         <= '0;
      cnt_reg       <= '0;
      shot_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      cnt_reg       <= cnt_next;
      shot_done_reg <= shot_done_next;
    end
  end

  // Next-state logic: launch, flight with hit taking priority over the frame
  // step, and the frame-counted cooldown. Position only changes at launch or
  // on a frame tick, so downstream logic can sample it at any time.
  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    cnt_next       = cnt_reg;
    shot_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next = FLYING;
          x_next     = bus.gunPosition;
          y_next     = LAUNCH_Y;
        end
      end
      FLYING: begin
        if (bus.hit) begin
          state_next     = COOLDOWN;
          cnt_next       = '0;
          shot_done_next = 1'b1;
        end else if (bus.frame_tick) begin
          if (y_reg < STEP) begin
            state_next     = COOLDOWN;
            cnt_next       = '0;
            shot_done_next = 1'b1;
          end else begin
            y_next = y_reg - STEP;
          end
        end
      end
      COOLDOWN: begin
        if (bus.frame_tick) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Laser pixel window. Horizontal edges saturate at the screen borders so a
  // ship parked at either edge still gets a correct, non-wrapping window.
  always_comb begin
    x_lo = (x_reg < HALF_W) ? 10'd0 : (x_reg - HALF_W);
    x_hi = (x_reg > (X_MAX - HALF_W)) ? X_MAX : (x_reg + HALF_W);
    y_bot = {1'b0, y_reg} + Y_SPAN;
    if (y_bot > Y_MAX) begin
      y_bot = Y_MAX;
    end
    in_window = active
             && (bus.hPos >= x_lo) && (bus.hPos <= x_hi)
             && ({1'b0, bus.vPos} >= {1'b0, y_reg})
             && ({1'b0, bus.vPos} <= y_bot);
  end

  // Registered colour output, one cycle behind hPos/vPos.
  always_ff @(posedge clk) begin
    if (reset) begin
      color_reg <= COLOR_NONE;
    end else begin
      color_reg <= in_window ? COLOR_LASER : COLOR_NONE;
    end
  end

  assign bus.laser_active = active;
  assign bus.laser_x      = x_reg;
  assign bus.laser_y      = y_reg;
  assign bus.shot_done    = shot_done_reg;
  assign bus.color        = color_reg;

endmodule

// File: tb/tb_laser_cannon.sv
// tb_laser_cannon: directed plus randomized stimulus for laser_cannon,
// checked every cycle against a shot-level reference model (a shot is either
// in the air, or we are waiting out a number of remaining cooldown frames).
`timescale 1ns/1ps
module tb_laser_cannon;
  localparam int SW = 640;
  localparam int LAUNCH_Y = 440 - 12;
  localparam int LH = 12;
  localparam int STEP = 8;
  localparam int COOL = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  laser_cannon_if bus();

  laser_cannon dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: shot in flight, position, frames of cooldown left.
  bit m_active;
  int m_x, m_y;
  bit m_done;
  int m_color;
  int m_cool_left;
  bit m_fire_prev;
  int m_launches = 0;
  int d_launches = 0;
  bit d_prev_active = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_color(bit act, int x, int y, int h, int v);
    int lo, hi;
    lo = (x - 1 < 0) ? 0 : x - 1;
    hi = (x + 1 > SW - 1) ? SW - 1 : x + 1;
    return (act && h >= lo && h <= hi && v >= y && v <= y + LH - 1) ? 6 : 7;
  endfunction

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_update();
    bit want;
    if (reset) begin
      m_active = 0; m_x = SW / 2; m_y = 0; m_done = 0; m_color = 7;
      m_cool_left = 0; m_fire_prev = 1;
      return;
    end
    m_color = exp_color(m_active, m_x, m_y, int'(bus.hPos), int'(bus.vPos));
`ifdef LASER_AUTOFIRE_EN
    want = bus.fire;
`else
    want = bus.fire && !m_fire_prev;
`endif
    m_done = 0;
    if (m_active) begin
      if (bus.hit) begin
        m_active = 0; m_cool_left = COOL; m_done = 1;
      end else if (bus.frame_tick) begin
        if (m_y < STEP) begin
          m_active = 0; m_cool_left = COOL; m_done = 1;
        end else begin
          m_y = m_y - STEP;
        end
      end
    end else if (m_cool_left > 0) begin
      if (bus.frame_tick) m_cool_left--;
    end else if (want) begin
      m_active = 1; m_x = int'(bus.gunPosition); m_y = LAUNCH_Y;
      m_launches++;
      $display("launch #%0d at x=%0d t=%0t", m_launches, m_x, $time);
    end
    m_fire_prev = bus.fire;
  endtask

  // One clock: update model, wait past the edge, compare every output.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    if (bus.laser_active && !d_prev_active) d_launches++;
    d_prev_active = bus.laser_active;
    check("laser_active", bus.laser_active, m_active);
    check("laser_x", bus.laser_x, m_x);
    check("laser_y", bus.laser_y, m_y);
    check("shot_done", bus.shot_done, m_done);
    check("color", bus.color, m_color);
  endtask

  task automatic tick();
    bus.frame_tick = 1; step();
    bus.frame_tick = 0; step();
  endtask

  task automatic end_shot_and_cool();
    bus.hit = 1; step();
    bus.hit = 0;
    repeat (COOL) tick();
  endtask

  initial begin
    int base_m, base_d;
    int guns[3];
    reset = 1;
    bus.fire = 0; bus.frame_tick = 0; bus.hit = 0;
    bus.gunPosition = 10'd320; bus.hPos = 0; bus.vPos = 0;
    repeat (3) step();
    check("rst_active", bus.laser_active, 0);
    check("rst_x", bus.laser_x, 320);
    check("rst_y", bus.laser_y, 0);
    check("rst_color", bus.color, 7);
    reset = 0;
    step();

    // Test 1: press in IDLE launches from the ship's nose.
    bus.fire = 1; step(); bus.fire = 0;
    check("t1_active", bus.laser_active, 1);
    check("t1_x", bus.laser_x, 320);
    check("t1_y", bus.laser_y, 428);
    step();
    check("t1_color_out", bus.color, 7);

    // Test 2: free flight to the top, then cooldown and relaunch.
    for (int i = 0; i < 53; i++) tick();
    check("t2_y_after53", bus.laser_y, 4);
    bus.frame_tick = 1; step(); bus.frame_tick = 0;
    check("t2_done", bus.shot_done, 1);
    check("t2_inactive", bus.laser_active, 0);
    step();
    check("t2_done_pulse", bus.shot_done, 0);
    repeat (COOL) tick();
    bus.fire = 1; step(); bus.fire = 0;
    check("t2_relaunch", bus.laser_active, 1);

    // Test 3: hit with simultaneous frame tick; press during cooldown dropped.
    for (int i = 0; i < 16; i++) tick();
    check("t3_y300", bus.laser_y, 300);
    bus.hit = 1; bus.frame_tick = 1; step();
    bus.hit = 0; bus.frame_tick = 0;
    check("t3_done", bus.shot_done, 1);
    check("t3_y_hold", bus.laser_y, 300);
    bus.fire = 1; step(); bus.fire = 0; step();
    repeat (COOL) tick();
    repeat (4) step();
    check("t3_no_queued", bus.laser_active, 0);
    bus.hit = 1; step(); bus.hit = 0;   // hit in IDLE is ignored
    check("t3_idle_hit", bus.shot_done, 0);

    // Test 4: colour window scan around x=320, y=300.
    bus.fire = 1; step(); bus.fire = 0;
    for (int i = 0; i < 16; i++) tick();
    for (int h = 318; h <= 322; h++) begin
      for (int v = 299; v <= 312; v++) begin
        bus.hPos = 10'(h); bus.vPos = 10'(v);
        step();
        check("t4_scan", bus.color,
              (h >= 319 && h <= 321 && v >= 300 && v <= 311) ? 6 : 7);
      end
    end
    end_shot_and_cool();
    // Edge-of-screen saturation at the launch row.
    guns[0] = 10; guns[1] = 0; guns[2] = SW - 1;
    foreach (guns[g]) begin
      bus.gunPosition = 10'(guns[g]);
      bus.fire = 1; step(); bus.fire = 0;
      for (int h = guns[g] - 3; h <= guns[g] + 3; h++) begin
        if (h < 0 || h > SW - 1) continue;
        bus.hPos = 10'(h); bus.vPos = 10'(LAUNCH_Y + 2);
        step();
        check("t4_edge", bus.color, (h >= guns[g] - 1 && h <= guns[g] + 1) ? 6 : 7);
      end
      end_shot_and_cool();
    end

    // Test 5: fire held through reset, press/release, reset mid-flight.
    bus.gunPosition = 10'd200;
    bus.fire = 1; reset = 1; repeat (2) step();
    reset = 0; repeat (3) step();
    bus.fire = 0; step();
    if (!m_active) begin
      bus.fire = 1; step(); bus.fire = 0;
    end
    tick(); tick();
    bus.hPos = bus.laser_x; bus.vPos = bus.laser_y;
    step();
    check("t5_color_on", bus.color, 6);
    reset = 1; step();
    check("t5_rst_active", bus.laser_active, 0);
    check("t5_rst_color", bus.color, 7);
    reset = 0; step();

    // Test 6: fire held constantly; launches must match the model.
    base_m = m_launches; base_d = d_launches;
    bus.gunPosition = 10'd320;
    bus.fire = 1;
    for (int i = 0; i < 140; i++) begin
      bus.frame_tick = 1; step(); bus.frame_tick = 0; step(); step();
    end
    bus.fire = 0; step();
    check("t6_launch_count", d_launches - base_d, m_launches - base_m);
`ifndef LASER_AUTOFIRE_EN
    check("t6_single_launch", d_launches - base_d, 1);
`endif
    end_shot_and_cool();

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      bus.frame_tick = ($urandom_range(0, 11) == 0);
      bus.hit = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) bus.fire = ~bus.fire;
      case ($urandom_range(0, 5))
        0: bus.gunPosition = 10'd0;
        1: bus.gunPosition = 10'(SW - 1);
        2: bus.gunPosition = 10'd1;
        default: bus.gunPosition = 10'($urandom_range(0, SW - 1));
      endcase
      if ($urandom_range(0, 1) == 0) begin
        bus.hPos = 10'(m_x + $urandom_range(0, 6) - 3);
        bus.vPos = 10'(m_y + $urandom_range(0, 16) - 2);
      end else begin
        bus.hPos = 10'($urandom_range(0, 1023));
        bus.vPos = 10'($urandom_range(0, 1023));
      end
      reset = ($urandom_range(0, 1499) == 0);
      step();
    end
    reset = 0; bus.frame_tick = 0; bus.hit = 0;
    step();
    check("total_launches", d_launches, m_launches);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
